fir_tap_pair_feeder: RTL and testbench



---
 rtl/fir_tap_pair_feeder.sv | 159 +++++++++++++++
 tb/tb_fir_tap_pair_feeder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_pair_feeder.sv
// fir_tap_pair_feeder
// Circular tap buffer for the antisymmetric FIR datapath. Every accepted
// sample is written into the buffer, then the tap pairs
// (x[n-k], x[n-(TAPS-1-k)]) are streamed out one per handshake to the
// downstream subtractor.
// Build option: define FIR_PAIR_INVERT_EN to present ~x[n-(TAPS-1-k)] on
// pair_b with pair_cin=1, so the next stage can compute a-b as a + ~b + 1.
module fir_tap_pair_feeder #(
    parameter int DATAWIDTH = 8,
    parameter int TAPS      = 16,
    parameter int IDXW      = $clog2(TAPS/2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] pair_a,
    output logic [DATAWIDTH-1:0] pair_b,
    output logic                 pair_cin,
    output logic [IDXW-1:0]      pair_idx,
    output logic                 pair_last,
    output logic                 pair_valid,
    input  logic                 pair_ready,
    output logic                 busy
);

    // Pointer width is one bit wider than the pair index because TAPS is even.
    localparam int PW = IDXW + 1;
    localparam logic [PW-1:0]   LAST_AGE = PW'(TAPS - 1);
    localparam logic [PW:0]     TAPS_EXT = (PW+1)'(TAPS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TAPS/2 - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [DATAWIDTH-1:0]   mem_q [TAPS];
    logic [PW-1:0]          wr_ptr_q;
    logic [DATAWIDTH-1:0]   a_q, b_q;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic                   last_q;

    logic                   accept_s;
    logic                   load_s;
    logic [PW-1:0]          wr_next_s;
    logic [PW-1:0]          rd_ptr_s;
    logic [DATAWIDTH-1:0]   a_raw_s, b_raw_s, b_sel_s;

    // Physical slot of the sample that is 'age' samples older than slot 'ptr';
    // the wrap is explicit so TAPS need not be a power of two.
    function automatic logic [PW-1:0] age_addr(input logic [PW-1:0] ptr,
                                               input logic [PW-1:0] age);
        if (ptr >= age) begin
            age_addr = ptr - age;
        end else begin
            age_addr = PW'({1'b0, ptr} + TAPS_EXT - {1'b0, age});
        end
    endfunction

    // Optional one's-complement of the older tap for the a + ~b + 1 subtractor.
    function automatic logic [DATAWIDTH-1:0] b_condition(input logic [DATAWIDTH-1:0] x);
`ifdef FIR_PAIR_INVERT_EN
        b_condition = ~x;
`else
        b_condition = x;
`endif
    endfunction

`ifdef FIR_PAIR_INVERT_EN
    assign pair_cin = 1'b1;
`else
    assign pair_cin = 1'b0;
`endif

    // While rst is high nothing may be accepted, so in_ready is forced low.
    assign in_ready   = (state_q == IDLE) && !rst;
    assign pair_valid = (state_q == EMIT);
    assign busy       = (state_q == EMIT);
    assign pair_a     = a_q;
    assign pair_b     = b_q;
    assign pair_idx   = idx_q;
    assign pair_last  = last_q;

    // Next state, next pair index and the tap read for the pair being loaded.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        load_s   = 1'b0;
        accept_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept_s = 1'b1;
                    load_s   = 1'b1;
                    idx_d    = {IDXW{1'b0}};
                    state_d  = EMIT;
                end else begin
                    state_d  = IDLE;
                end
            end
            EMIT: begin
                if (pair_ready && last_q) begin
                    state_d = IDLE;
                end else if (pair_ready) begin
                    idx_d  = idx_q + IDXW'(1);
                    load_s = 1'b1;
                end else begin
                    state_d = EMIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wr_next_s = (wr_ptr_q == LAST_AGE) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
        // On accept the newest slot is the one being written this edge.
        rd_ptr_s  = accept_s ? wr_next_s : wr_ptr_q;
        if (accept_s) begin
            a_raw_s = in_data;
        end else begin
            a_raw_s = mem_q[age_addr(rd_ptr_s, {1'b0, idx_d})];
        end
        // The oldest tap of the k=0 pair is never the slot being written.
        b_raw_s = mem_q[age_addr(rd_ptr_s, LAST_AGE - {1'b0, idx_d})];
        b_sel_s = b_condition(b_raw_s);
    end

    // State, tap buffer, write pointer and registered pair outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= LAST_AGE;
            a_q      <= {DATAWIDTH{1'b0}};
            b_q      <= {DATAWIDTH{1'b0}};
            idx_q    <= {IDXW{1'b0}};
            last_q   <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                mem_q[i] <= {DATAWIDTH{1'b0}};
            end
        end else begin
            state_q <= state_d;
            if (accept_s) begin
                mem_q[wr_next_s] <= in_data;
                wr_ptr_q         <= wr_next_s;
            end
            if (load_s) begin
                a_q    <= a_raw_s;
                b_q    <= b_sel_s;
                idx_q  <= idx_d;
                last_q <= (idx_d == LAST_IDX);
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_pair_feeder.sv
// Directed bench for fir_tap_pair_feeder with DATAWIDTH=8, TAPS=4.
// Define FIR_PAIR_INVERT_EN for both files to check the inverting build.
module tb_fir_tap_pair_feeder;

    localparam int DW   = 8;
    localparam int TAPS = 4;
    localparam int IDXW = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   pair_a;
    logic [DW-1:0]   pair_b;
    logic            pair_cin;
    logic [IDXW-1:0] pair_idx;
    logic            pair_last;
    logic            pair_valid;
    logic            pair_ready;
    logic            busy;

    int checks = 0;
    int errors = 0;

`ifdef FIR_PAIR_INVERT_EN
    localparam logic EXP_CIN = 1'b1;
`else
    localparam logic EXP_CIN = 1'b0;
`endif

    fir_tap_pair_feeder #(.DATAWIDTH(DW), .TAPS(TAPS)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pair_a     (pair_a),
        .pair_b     (pair_b),
        .pair_cin   (pair_cin),
        .pair_idx   (pair_idx),
        .pair_last  (pair_last),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_b(input logic [DW-1:0] x);
`ifdef FIR_PAIR_INVERT_EN
        return ~x;
`else
        return x;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pair(input string tag, input logic [DW-1:0] a,
                              input logic [DW-1:0] b, input logic idx, input logic last);
        check({tag, ".valid"}, {31'd0, pair_valid}, 32'd1);
        check({tag, ".a"},     {24'd0, pair_a},     {24'd0, a});
        check({tag, ".b"},     {24'd0, pair_b},     {24'd0, exp_b(b)});
        check({tag, ".cin"},   {31'd0, pair_cin},   {31'd0, EXP_CIN});
        check({tag, ".idx"},   {31'd0, pair_idx},   {31'd0, idx});
        check({tag, ".last"},  {31'd0, pair_last},  {31'd0, last});
        check({tag, ".in_rdy"},{31'd0, in_ready},   32'd0);
        check({tag, ".busy"},  {31'd0, busy},       32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"},  {31'd0, pair_valid}, 32'd0);
        check({tag, ".in_rdy"}, {31'd0, in_ready},   32'd1);
        check({tag, ".busy"},   {31'd0, busy},       32'd0);
    endtask

    task automatic push(input logic [DW-1:0] v);
        in_data  = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        pair_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!pair_valid) break;
            step();
        end
        check({tag, ".drained"}, {31'd0, pair_valid}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        pair_ready = 1'b1;
        #1;
        check("rst.in_rdy_during", {31'd0, in_ready}, 32'd0);
        step();
        check("rst.in_rdy_held", {31'd0, in_ready}, 32'd0);
        check("rst.valid", {31'd0, pair_valid}, 32'd0);
        check("rst.busy",  {31'd0, busy},       32'd0);
        check("rst.a",     {24'd0, pair_a},     32'd0);
        check("rst.b",     {24'd0, pair_b},     32'd0);
        check("rst.idx",   {31'd0, pair_idx},   32'd0);
        check("rst.last",  {31'd0, pair_last},  32'd0);
        check("rst.cin",   {31'd0, pair_cin},   {31'd0, EXP_CIN});
        rst = 1'b0;
        #1;
        check_idle("rst.after");

        // Single sample: unwritten slots read as zero.
        push(8'h11);
        check_pair("s1.p0", 8'h11, 8'h00, 1'b0, 1'b0);
        step();
        check_pair("s1.p1", 8'h00, 8'h00, 1'b1, 1'b1);
        step();
        check_idle("s1.idle");

        // Fill the buffer: slots 1,2,3 then 0.
        push(8'h01); drain("s2.d1");
        push(8'h02); drain("s2.d2");
        push(8'h03); drain("s2.d3");
        push(8'h04);
        check_pair("s2.p0", 8'h04, 8'h01, 1'b0, 1'b0);
        step();
        check_pair("s2.p1", 8'h03, 8'h02, 1'b1, 1'b1);
        step();
        check_idle("s2.idle");

        // Pointer wraps 0 -> 1.
        push(8'h05);
        check_pair("s3.p0", 8'h05, 8'h02, 1'b0, 1'b0);
        step();
        check_pair("s3.p1", 8'h04, 8'h03, 1'b1, 1'b1);
        step();
        check_idle("s3.idle");

        // Backpressure on idx0 with in_valid pulses that must be ignored.
        pair_ready = 1'b0;
        push(8'h06);
        check_pair("bp.p0", 8'h06, 8'h03, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_data  = 8'hAA;
            in_valid = (i != 1);
            step();
            check_pair("bp.hold", 8'h06, 8'h03, 1'b0, 1'b0);
        end
        in_valid   = 1'b0;
        pair_ready = 1'b1;
        step();
        check_pair("bp.p1", 8'h05, 8'h04, 1'b1, 1'b1);
        step();
        check_idle("bp.idle");

        // Reset during idx0, then reset together with a valid sample.
        pair_ready = 1'b0;
        push(8'h08);
        check_pair("mr.p0", 8'h08, 8'h04, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        in_data  = 8'h55;
        in_valid = 1'b1;
        #1;
        check("mr.in_rdy_rst", {31'd0, in_ready}, 32'd0);
        step();
        rst        = 1'b0;
        in_valid   = 1'b0;
        pair_ready = 1'b1;
        #1;
        check_idle("mr.after");
        check("mr.a",   {24'd0, pair_a},   32'd0);
        check("mr.idx", {31'd0, pair_idx}, 32'd0);
        push(8'h07);
        check_pair("mr.p0b", 8'h07, 8'h00, 1'b0, 1'b0);
        step();
        check_pair("mr.p1b", 8'h00, 8'h00, 1'b1, 1'b1);
        step();
        check_idle("mr.idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
